// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns per-frame keycodes into edge-detected, auto-repeating move commands
// merged with a level-dependent gravity tick onto one valid/ready command stream.
module move_cmd_gen #(
    parameter int DAS_DELAY      = 16,
    parameter int ARR_PERIOD     = 4,
    parameter int GRAVITY_PERIOD = 48,
    parameter int GRAVITY_MIN    = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [3:0] level,
    input  logic       pause,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd
);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    localparam logic [2:0] C_LEFT = 3'd1, C_RIGHT = 3'd2, C_DOWN = 3'd3, C_ROT = 3'd4;

    state_t      state_q, state_d;
    logic [7:0]  prev_key_q, das_q, das_d, grav_q, grav_d, period;
    logic [2:0]  key_pend_q, key_pend_d, cmd_d, code;
    logic        grav_pend_q, grav_pend_d, valid_d, key_hit, key_req, soft_drop, grav_req, free;
    logic signed [8:0] period_s;

    always_comb begin
        code = keycode == 8'h04 ? C_LEFT : keycode == 8'h07 ? C_RIGHT :
               keycode == 8'h16 ? C_DOWN : keycode == 8'h1A ? C_ROT : 3'd0;
        state_d = state_q;
        das_d   = das_q;
        key_hit = 1'b0;
        if (code == 3'd0) begin
            state_d = IDLE;
            das_d   = 8'd0;
        end else if (keycode != prev_key_q) begin
            state_d = HELD;
            das_d   = 8'd0;
            key_hit = 1'b1;
        end else if (state_q == HELD && code != C_ROT) begin
            state_d = das_q == 8'(DAS_DELAY - 1) ? REPEAT : HELD;
            key_hit = das_q == 8'(DAS_DELAY - 1);
            das_d   = key_hit ? 8'd0 : das_q + 8'd1;
        end else if (state_q == REPEAT) begin
            key_hit = das_q == 8'(ARR_PERIOD - 1);
            das_d   = key_hit ? 8'd0 : das_q + 8'd1;
        end
        key_req   = key_hit & ~pause;
        soft_drop = key_req & (code == C_DOWN);
        // signed intermediate so high levels clamp instead of wrapping
        period_s  = $signed(9'(GRAVITY_PERIOD)) - $signed({3'b000, level, 2'b00});
        period    = period_s < $signed(9'(GRAVITY_MIN)) ? 8'(GRAVITY_MIN) : period_s[7:0];
        grav_req  = ~pause & ~soft_drop & (grav_q >= period - 8'd1);
        grav_d    = pause ? grav_q : (grav_req | soft_drop) ? 8'd0 : grav_q + 8'd1;
        free        = ~cmd_valid | cmd_ready;
        valid_d     = cmd_valid;
        cmd_d       = cmd;
        key_pend_d  = key_pend_q;
        grav_pend_d = grav_pend_q | grav_req;
        if (free) begin
            valid_d = 1'b1;
            if (key_pend_q != 3'd0) begin
                cmd_d      = key_pend_q;
                key_pend_d = key_req ? code : 3'd0;
            end else if (key_req) begin
                cmd_d = code;
            end else if (grav_pend_q) begin
                cmd_d       = C_DOWN;
                grav_pend_d = grav_req;
            end else if (grav_req) begin
                cmd_d       = C_DOWN;
                grav_pend_d = 1'b0;
            end else begin
                valid_d = 1'b0;
                cmd_d   = 3'd0;
            end
        end else if (key_req && key_pend_q == 3'd0) begin
            key_pend_d = code;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            prev_key_q  <= 8'd0;
            das_q       <= 8'd0;
            grav_q      <= 8'd0;
            key_pend_q  <= 3'd0;
            grav_pend_q <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd         <= 3'd0;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= keycode;
            das_q       <= das_d;
            grav_q      <= grav_d;
            key_pend_q  <= key_pend_d;
            grav_pend_q <= grav_pend_d;
            cmd_valid   <= valid_d;
            cmd         <= cmd_d;
        end
    end
endmodule

// File: tb/tb_move_cmd_gen.sv
// tb_move_cmd_gen: directed scenarios plus random keycode/level/pause/ready traffic
// compared frame by frame against a hold-time and candidate-list reference model.
module tb_move_cmd_gen;
    localparam int DAS = 16, ARR = 4, GP = 48, GMIN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = 8'h00;
    logic [3:0] lvl = 4'd0;
    logic       pse = 1'b0;
    logic       rdy = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd;

    int tests = 0, fails = 0;

    // reference state: output, pending slots, key hold time, gravity elapsed frames
    logic       m_valid;
    logic [2:0] m_cmd;
    int         m_kp, m_held, m_elapsed;
    bit         m_gp;
    logic [7:0] m_prev;

    move_cmd_gen dut (
        .frame_clk(clk), .Reset(rst_n), .keycode(key), .level(lvl), .pause(pse),
        .cmd_ready(rdy), .cmd_valid(cmd_valid), .cmd(cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] k);
        case (k)
            8'h04:   return 1;
            8'h07:   return 2;
            8'h16:   return 3;
            8'h1A:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic [7:0] k, input logic [3:0] l,
                                       input logic p, input logic rd);
        int code, period, first;
        bit kreq, greq;
        int cand[$];
        if (!r) begin
            m_valid = 0; m_cmd = 0; m_kp = 0; m_gp = 0; m_held = 0; m_elapsed = 0; m_prev = 0;
            return;
        end
        code = decode(k);
        kreq = 0;
        if (code != 0) begin
            m_held = (k != m_prev) ? 0 : m_held + 1;
            kreq = !p && (m_held == 0 ||
                   (code != 4 && m_held >= DAS && (m_held - DAS) % ARR == 0));
        end
        m_prev = k;
        period = GP - 4 * int'(l);
        if (period < GMIN) period = GMIN;
        greq = 0;
        if (!p) begin
            if (kreq && code == 3) m_elapsed = 0;
            else begin
                m_elapsed++;
                if (m_elapsed >= period) begin greq = 1; m_elapsed = 0; end
            end
        end
        // priority-ordered candidates; 10 marks a gravity DOWN
        if (m_kp != 0) cand.push_back(m_kp);
        if (kreq) cand.push_back(code);
        if (m_gp) cand.push_back(10);
        if (greq) cand.push_back(10);
        if (!m_valid || rd) begin
            if (cand.size() > 0) begin
                first = cand.pop_front();
                m_valid = 1;
                m_cmd = (first == 10) ? 3'd3 : 3'(first);
            end else begin
                m_valid = 0;
                m_cmd = 0;
            end
        end
        m_kp = 0;
        m_gp = 0;
        foreach (cand[i]) begin
            if (cand[i] == 10) m_gp = 1;
            else if (m_kp == 0) m_kp = cand[i];
        end
    endfunction

    task automatic step(input logic r, input logic [7:0] k, input logic [3:0] l,
                        input logic p, input logic rd);
        rst_n = r; key = k; lvl = l; pse = p; rdy = rd;
        @(posedge clk);
        model_step(r, k, l, p, rd);
        #1;
        check("valid", 8'(cmd_valid), 8'(m_valid));
        check("cmd", 8'(cmd), 8'(m_cmd));
    endtask

    initial begin
        int n, sum, first_idx, hold;
        logic [7:0] k;
        logic [7:0] keys [5];
        keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h16; keys[4] = 8'h1A;
        // reset dominates a held key
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h04, 0, 0, 1);
            check("rst_valid", 8'(cmd_valid), 8'd0);
            check("rst_cmd", 8'(cmd), 8'd0);
        end
        step(1, 8'h04, 0, 0, 1);
        check("first_left", 8'(cmd), 8'd1);
        // RIGHT held: press, DAS, then ARR repeats
        step(0, 8'h00, 0, 0, 1);
        n = 0; sum = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 8'h07, 0, 0, 1);
            if (cmd_valid && cmd == 3'd2) begin n++; sum += i; end
        end
        check("right_count", 8'(n), 8'd5);
        check("right_edges", 8'(sum), 8'd88);
        // ROTATE never repeats
        step(0, 8'h00, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 8'h1A, 0, 0, 1);
            if (cmd_valid && cmd == 3'd4) n++;
        end
        check("rot_count", 8'(n), 8'd1);
        // gravity at level 0
        step(0, 8'h00, 0, 0, 1);
        n = 0; first_idx = -1;
        for (int i = 0; i < 96; i++) begin
            step(1, 8'h00, 0, 0, 1);
            if (cmd_valid && cmd == 3'd3) begin n++; if (first_idx < 0) first_idx = i; end
        end
        check("grav0_count", 8'(n), 8'd2);
        check("grav0_first", 8'(first_idx), 8'd47);
        // level 15 clamps to the minimum period
        step(0, 8'h00, 15, 0, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 8'h00, 15, 0, 1);
            if (cmd_valid && cmd == 3'd3) n++;
        end
        check("grav15_count", 8'(n), 8'd5);
        // stalled ROTATE while gravity merges behind it
        step(0, 8'h00, 15, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 8'h1A, 15, 0, 0);
            check("stall_cmd", 8'(cmd), 8'd4);
        end
        step(1, 8'h1A, 15, 0, 1);
        check("after_stall", 8'(cmd), 8'd3);
        step(1, 8'h1A, 15, 0, 1);
        // reset in the middle of a repeat
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 18; i++) step(1, 8'h04, 0, 0, 1);
        step(0, 8'h04, 0, 0, 1);
        check("midrst_valid", 8'(cmd_valid), 8'd0);
        step(1, 8'h04, 0, 0, 1);
        check("relaunch_left", 8'(cmd), 8'd1);
        for (int i = 0; i < 16; i++) step(1, 8'h04, 0, 0, 1);
        check("relaunch_das", 8'(cmd), 8'd1);
        // random traffic
        hold = 0;
        k = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                k = ($urandom_range(0, 5) == 5) ? 8'($urandom) : keys[$urandom_range(0, 4)];
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 50) == 0) lvl = 4'($urandom);
            step($urandom_range(0, 99) != 0, k, lvl, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
